axis_video_converter: RTL and testbench
=======================================

Name: axis_video_converter

Overview:
- Converts an AXI4-Stream video pixel stream (one RGB pixel per beat) into a parallel video pixel bus with data-valid, start-of-frame and end-of-frame strobes.
- Sits between an AXIS video producer (HLS core, DMA) and a native video sink (display or timing pipeline).
- Input beats are buffered in an internal FIFO. Frame and line position are tracked against the runtime resolution inputs.
- Optional debubbling releases each line in bursts, so output gaps are reduced.

Parameters:
- C_WIDTH, 8, bits per colour component; tdata is 3*C_WIDTH wide.
- TUSER_WIDTH, 2, tuser width; bit0 = SOF, bit1 = EOF, higher bits ignored (TUSER_WIDTH >= 2 required).
- FIFO_DEPTH, 32, pixel FIFO depth in entries; power of two, >= 4.
- RES_WIDTH, 16, width of i_hres/i_vres and of the internal x/y counters.
- DEBUBBLE, 0, 1 = hold off line output until FIFO is full or holds a tlast beat.

Ports:
- i_axis_clk, in, 1, single clock for all logic.
- i_axis_reset, in, 1, asynchronous active-high reset.
- i_tdata, in, 3*C_WIDTH, pixel: R=[C_WIDTH-1:0], G=[2C_WIDTH-1:C_WIDTH], B=[3C_WIDTH-1:2C_WIDTH].
- i_tvalid, in, 1, AXIS valid.
- i_tuser, in, TUSER_WIDTH, [0]=SOF, [1]=EOF.
- i_tlast, in, 1, end of line.
- i_hres, in, RES_WIDTH, active pixels per line (>= 1), sampled quasi-statically.
- i_vres, in, RES_WIDTH, active lines per frame (>= 1).
- o_tready, out, 1, AXIS ready.
- o_data_valid, out, 1, o_R/o_G/o_B hold a valid pixel this cycle.
- o_R, o_G, o_B, out, C_WIDTH each, pixel components.
- o_frame_start, out, 1, pulses with the first pixel of a frame.
- o_EOF, out, 1, pulses with the last pixel of a frame.

Behaviour:
- Reset (async assert, sync release): FIFO empty, counters x=y=0.
  - Outputs during reset: o_tready=0, o_data_valid=0, o_R/G/B=0, o_frame_start=0, o_EOF=0.
  - o_tready rises the first cycle after reset deasserts.
- Input handshake:
  - o_tready = FIFO not full.
  - Beat accepted on i_tvalid & o_tready at rising edge.
  - Stored per entry: {tdata, tuser[1:0], tlast}.
  - o_tready is independent of i_tvalid.
  - Simultaneous push and pop while full: only the pop occurs, since o_tready=0.
- Output (all outputs registered):
  - A pop loads o_R/G/B from the entry and sets o_data_valid=1.
  - o_frame_start = entry tuser[0].
  - o_EOF = entry tuser[1] OR (x==i_hres-1 AND y==i_vres-1).
  - When no pop occurs: o_data_valid=0, strobes=0, o_R/G/B hold their last value.
  - The sink is always ready; no backpressure output.
- Latency: with DEBUBBLE=0, a beat accepted at edge N appears on the outputs after edge N+2. One entry can pop per cycle, so steady-state throughput is 1 pixel/clk.
- DEBUBBLE=0: pop whenever the FIFO is non-empty.
- DEBUBBLE=1: state machine IDLE/BURST.
  - IDLE -> BURST when the FIFO is full or contains at least one tlast-tagged entry.
  - In BURST, pop every cycle the FIFO is non-empty.
  - BURST -> IDLE after popping a tlast entry.
- Counters advance on each pop:
  - x increments; it wraps to 0 on a popped tlast or at x==i_hres-1, and y then increments.
  - y wraps to 0 after the last line or on a popped EOF.
  - A popped SOF forces x=1, y=0 after that pop.
- Boundaries:
  - Empty FIFO: no pop, o_data_valid=0.
  - FIFO pointers wrap modulo FIFO_DEPTH, with a separate count for full/empty.
  - Reset mid-frame flushes the FIFO and discards the partial frame.

Optional Feature:
- Macro: AXIS_VIDEO_SOF_RESYNC_EN.
- Defined:
  - After reset, the block is in a "sync-lost" state.
  - In sync-lost, accepted beats are discarded (o_tready=1) until a beat with tuser[0]=1 arrives.
  - The SOF beat itself is stored, and the block leaves sync-lost.
  - An SOF beat accepted while x!=0 or y!=0 at the input-side counter also resets that counter; the beat is stored normally.
- Undefined: every beat is stored from reset; there is no sync-lost state.

Test Plan:
- Reset hold 5 clk, then 100x100 frame, tdata=0..9999, tvalid continuous, DEBUBBLE=0:
  - o_data_valid high 10000 cycles total.
  - First pixel o_R=0x00 with o_frame_start=1.
  - Pixel 9999 (0x270F) appears as R=0x0F, G=0x27, B=0x00 with o_EOF=1.
- Same stream with tvalid dropped 4 clk every 30 accepted beats, 2 frames:
  - Output pixel order unbroken, 20000 valid pixels.
  - Exactly 2 o_frame_start pulses and 2 o_EOF pulses.
- DEBUBBLE=1, HRES=20, tvalid toggling every cycle:
  - Each line of 20 pixels is output as a contiguous o_data_valid run starting after the tlast beat is buffered.
- Sink stalled via FIFO fill (tvalid held, DEBUBBLE=1, no tlast for 40 beats) -> o_tready=0 once 32 entries are stored; resumes after a burst pops.
- Assert i_axis_reset mid-line, tvalid high -> outputs 0 immediately (async), o_tready=0; after release, next frame starts clean with o_frame_start on its first pixel.
- AXIS_VIDEO_SOF_RESYNC_EN defined, 37 beats without SOF then a frame -> first 37 beats never output; first output pixel carries o_frame_start=1.

Source files
------------

// File: rtl/axis_video_converter.sv
`default_nettype none
// ============================================================================
// Module      : axis_video_converter
// Description : AXI4-Stream video (one RGB pixel per beat) to parallel video
//               bus with data-valid, start-of-frame and end-of-frame strobes.
//               Beats are buffered in a pixel FIFO; frame/line position is
//               tracked against the runtime i_hres/i_vres inputs.
//               Optional macro AXIS_VIDEO_SOF_RESYNC_EN: after reset, beats
//               are discarded until the first SOF beat arrives.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_video_converter #(
  parameter int C_WIDTH     = 8,
  parameter int TUSER_WIDTH = 2,
  parameter int FIFO_DEPTH  = 32,
  parameter int RES_WIDTH   = 16,
  parameter int DEBUBBLE    = 0
) (
  input  logic                   i_axis_clk,
  input  logic                   i_axis_reset,
  input  logic [3*C_WIDTH-1:0]   i_tdata,
  input  logic                   i_tvalid,
  input  logic [TUSER_WIDTH-1:0] i_tuser,
  input  logic                   i_tlast,
  input  logic [RES_WIDTH-1:0]   i_hres,
  input  logic [RES_WIDTH-1:0]   i_vres,
  output logic                   o_tready,
  output logic                   o_data_valid,
  output logic [C_WIDTH-1:0]     o_R,
  output logic [C_WIDTH-1:0]     o_G,
  output logic [C_WIDTH-1:0]     o_B,
  output logic                   o_frame_start,
  output logic                   o_EOF
);

  localparam int C_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int C_CW = C_AW + 1;
  localparam int C_DW = 3 * C_WIDTH;
  localparam int C_EW = C_DW + 3;

  localparam logic [C_CW-1:0]      C_FULL    = C_CW'(FIFO_DEPTH);
  localparam logic [C_CW-1:0]      C_CNT_ONE = C_CW'(1);
  localparam logic [C_AW-1:0]      C_PTR_ONE = C_AW'(1);
  localparam logic [RES_WIDTH-1:0] C_RES_ONE = RES_WIDTH'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // FIFO storage and bookkeeping
  logic [C_EW-1:0]      r_mem [FIFO_DEPTH];
  logic [C_AW-1:0]      r_wr_ptr;
  logic [C_AW-1:0]      r_rd_ptr;
  logic [C_CW-1:0]      r_count;
  logic [C_CW-1:0]      w_count_next;
  logic                 r_tready;

  logic                 w_accept;
  logic                 w_store;
  logic                 w_pop_en;
  logic                 w_pop;
  logic                 w_empty;

  // Head-of-FIFO entry fields: {tdata, eof, sof, tlast}
  logic [C_EW-1:0]      w_head;
  logic [C_DW-1:0]      w_head_data;
  logic                 w_head_eof;
  logic                 w_head_sof;
  logic                 w_head_last;

  // Output-side position counters
  logic [RES_WIDTH-1:0] r_x;
  logic [RES_WIDTH-1:0] r_y;
  logic [RES_WIDTH-1:0] w_hres_m1;
  logic [RES_WIDTH-1:0] w_vres_m1;
  logic                 w_x_last;
  logic                 w_y_last;
  logic                 w_frame_end;
  logic                 w_line_end;

  // Pop stage and output stage registers
  logic                 r_s1_vld;
  logic                 r_s1_sof;
  logic                 r_s1_eof;
  logic [C_DW-1:0]      r_s1_data;
  logic                 r_data_valid;
  logic                 r_frame_start;
  logic                 r_eof;
  logic [C_WIDTH-1:0]   r_R;
  logic [C_WIDTH-1:0]   r_G;
  logic [C_WIDTH-1:0]   r_B;

  assign w_accept    = i_tvalid & r_tready;
  assign w_empty     = (r_count == '0);
  assign w_pop       = w_pop_en & ~w_empty;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_data = w_head[C_EW-1:3];
  assign w_head_eof  = w_head[2];
  assign w_head_sof  = w_head[1];
  assign w_head_last = w_head[0];

  assign w_hres_m1   = i_hres - C_RES_ONE;
  assign w_vres_m1   = i_vres - C_RES_ONE;
  assign w_x_last    = (r_x == w_hres_m1);
  assign w_y_last    = (r_y == w_vres_m1);
  assign w_frame_end = w_x_last & w_y_last;
  assign w_line_end  = w_head_last | w_x_last | w_head_eof;

`ifdef AXIS_VIDEO_SOF_RESYNC_EN
  // Input-side sync tracking: nothing is stored until the first SOF beat
  logic                 r_sync_lost;
  logic [RES_WIDTH-1:0] r_in_x;
  logic [RES_WIDTH-1:0] r_in_y;

  assign w_store = w_accept & (~r_sync_lost | i_tuser[0]);

  // Sync-lost flag: set by reset, cleared by the first accepted SOF beat
  always_ff @(posedge i_axis_clk or posedge i_axis_reset) begin
    if (i_axis_reset) begin
      r_sync_lost <= 1'b1;
    end else if (w_accept & i_tuser[0]) begin
      r_sync_lost <= 1'b0;
    end
  end

  // Input-side position counter; an SOF beat realigns it to the frame start
  always_ff @(posedge i_axis_clk or posedge i_axis_reset) begin
    if (i_axis_reset) begin
      r_in_x <= '0;
      r_in_y <= '0;
    end else if (w_store) begin
      if (i_tuser[0]) begin
        r_in_x <= C_RES_ONE;
        r_in_y <= '0;
      end else if (i_tlast | i_tuser[1] | (r_in_x == w_hres_m1)) begin
        r_in_x <= '0;
        r_in_y <= (i_tuser[1] | (r_in_y == w_vres_m1)) ? '0 : r_in_y + C_RES_ONE;
      end else begin
        r_in_x <= r_in_x + C_RES_ONE;
      end
    end
  end
`else
  assign w_store = w_accept;
`endif

  // Pop gating: either free-running, or line-burst release
  if (DEBUBBLE != 0) begin : g_debubble
    state_t          r_state;
    state_t          w_state_next;
    logic [C_CW-1:0] r_last_cnt;
    logic            w_full;
    logic            w_last_in;
    logic            w_last_out;

    assign w_full     = (r_count == C_FULL);
    assign w_last_in  = w_store & i_tlast;
    assign w_last_out = w_pop & w_head_last;
    assign w_pop_en   = (r_state == ST_BURST);

    // Number of tlast-tagged entries currently buffered
    always_ff @(posedge i_axis_clk or posedge i_axis_reset) begin
      if (i_axis_reset) begin
        r_last_cnt <= '0;
      end else begin
        case ({w_last_in, w_last_out})
          2'b10:   r_last_cnt <= r_last_cnt + C_CNT_ONE;
          2'b01:   r_last_cnt <= r_last_cnt - C_CNT_ONE;
          default: r_last_cnt <= r_last_cnt;
        endcase
      end
    end

    // Burst state register
    always_ff @(posedge i_axis_clk or posedge i_axis_reset) begin
      if (i_axis_reset) begin
        r_state <= ST_IDLE;
      end else begin
        r_state <= w_state_next;
      end
    end

    // Start a burst once a whole line (or a full FIFO) is buffered
    always_comb begin
      w_state_next = r_state;
      case (r_state)
        ST_IDLE:  if (w_full || (r_last_cnt != '0)) w_state_next = ST_BURST;
        ST_BURST: if (w_last_out) w_state_next = ST_IDLE;
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end else begin : g_passthrough
    assign w_pop_en = 1'b1;
  end

  // Next FIFO occupancy; a full FIFO never stores because ready is low
  always_comb begin
    w_count_next = r_count;
    case ({w_store, w_pop})
      2'b10:   w_count_next = r_count + C_CNT_ONE;
      2'b01:   w_count_next = r_count - C_CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  // FIFO pointers, occupancy and registered ready
  always_ff @(posedge i_axis_clk or posedge i_axis_reset) begin
    if (i_axis_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_tready <= 1'b0;
    end else begin
      if (w_store) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      r_count  <= w_count_next;
      r_tready <= (w_count_next != C_FULL);
    end
  end

  // FIFO storage write; contents need no reset since occupancy guards reads
  always_ff @(posedge i_axis_clk) begin
    if (w_store) begin
      r_mem[r_wr_ptr] <= {i_tdata, i_tuser[1], i_tuser[0], i_tlast};
    end
  end

  // Frame position counters advance on each pop
  always_ff @(posedge i_axis_clk or posedge i_axis_reset) begin
    if (i_axis_reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_pop) begin
      if (w_head_sof) begin
        r_x <= C_RES_ONE;
        r_y <= '0;
      end else if (w_line_end) begin
        r_x <= '0;
        r_y <= (w_head_eof | w_y_last) ? '0 : r_y + C_RES_ONE;
      end else begin
        r_x <= r_x + C_RES_ONE;
      end
    end
  end

  // Pop stage: capture head entry and resolve the end-of-frame strobe
  always_ff @(posedge i_axis_clk or posedge i_axis_reset) begin
    if (i_axis_reset) begin
      r_s1_vld  <= 1'b0;
      r_s1_sof  <= 1'b0;
      r_s1_eof  <= 1'b0;
      r_s1_data <= '0;
    end else begin
      r_s1_vld <= w_pop;
      r_s1_sof <= w_pop & w_head_sof;
      r_s1_eof <= w_pop & (w_head_eof | w_frame_end);
      if (w_pop) r_s1_data <= w_head_data;
    end
  end

  // Output stage: pixel holds its last value when nothing is popped
  always_ff @(posedge i_axis_clk or posedge i_axis_reset) begin
    if (i_axis_reset) begin
      r_data_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_eof         <= 1'b0;
      r_R           <= '0;
      r_G           <= '0;
      r_B           <= '0;
    end else begin
      r_data_valid  <= r_s1_vld;
      r_frame_start <= r_s1_sof;
      r_eof         <= r_s1_eof;
      if (r_s1_vld) begin
        r_R <= r_s1_data[C_WIDTH-1:0];
        r_G <= r_s1_data[2*C_WIDTH-1:C_WIDTH];
        r_B <= r_s1_data[3*C_WIDTH-1:2*C_WIDTH];
      end
    end
  end

  assign o_tready      = r_tready;
  assign o_data_valid  = r_data_valid;
  assign o_frame_start = r_frame_start;
  assign o_EOF         = r_eof;
  assign o_R           = r_R;
  assign o_G           = r_G;
  assign o_B           = r_B;

endmodule
`default_nettype wire

// File: tb/tb_axis_video_converter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_video_converter
// Description : Scoreboard bench for axis_video_converter. Instance 0 runs
//               with DEBUBBLE=0, instance 1 with DEBUBBLE=1. Expected pixels
//               are queued when a beat is accepted and popped as outputs
//               appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_video_converter;

  typedef struct packed {
    logic [23:0] d;
    logic        sof;
    logic        eof;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [23:0] tdata0, tdata1;
  logic        tvalid0, tvalid1, tlast0, tlast1;
  logic [1:0]  tuser0, tuser1;
  logic [15:0] hres0, vres0, hres1, vres1;
  logic        tready0, tready1, dv0, dv1, fs0, fs1, eof0, eof1;
  logic [7:0]  r0, g0, b0, r1, g1, b1;

  axis_video_converter #(.C_WIDTH(8), .TUSER_WIDTH(2), .FIFO_DEPTH(32),
                         .RES_WIDTH(16), .DEBUBBLE(0)) dut0 (
    .i_axis_clk(clk), .i_axis_reset(rst), .i_tdata(tdata0), .i_tvalid(tvalid0),
    .i_tuser(tuser0), .i_tlast(tlast0), .i_hres(hres0), .i_vres(vres0),
    .o_tready(tready0), .o_data_valid(dv0), .o_R(r0), .o_G(g0), .o_B(b0),
    .o_frame_start(fs0), .o_EOF(eof0));

  axis_video_converter #(.C_WIDTH(8), .TUSER_WIDTH(2), .FIFO_DEPTH(32),
                         .RES_WIDTH(16), .DEBUBBLE(1)) dut1 (
    .i_axis_clk(clk), .i_axis_reset(rst), .i_tdata(tdata1), .i_tvalid(tvalid1),
    .i_tuser(tuser1), .i_tlast(tlast1), .i_hres(hres1), .i_vres(vres1),
    .o_tready(tready1), .o_data_valid(dv1), .o_R(r1), .o_G(g1), .o_B(b1),
    .o_frame_start(fs1), .o_EOF(eof1));

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   n_vec = 0;
  int   n_fail = 0;
  int   vcnt0 = 0, fscnt0 = 0, eofcnt0 = 0;
  int   vcnt1 = 0, fscnt1 = 0, eofcnt1 = 0;
  int   run1 = 0, runs_seen = 0;
  bit   chk_runs = 1'b0;
  int   stall_at = -1, stall_vcnt = -1;
  localparam int BIG = 1000000;

  // Scoreboard: compare every output pixel with the queued expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (dv0) begin
        vcnt0++;
        if (fs0) fscnt0++;
        if (eof0) eofcnt0++;
        n_vec++;
        if (q0.size() == 0) begin
          n_fail++;
          $display("FAIL sb0_unexpected: got data=%h sof=%b eof=%b, required no output", {b0, g0, r0}, fs0, eof0);
        end else begin
          e0 = q0.pop_front();
          if ({b0, g0, r0, fs0, eof0} !== {e0.d, e0.sof, e0.eof}) begin
            n_fail++;
            $display("FAIL sb0_pixel: got data=%h sof=%b eof=%b, required data=%h sof=%b eof=%b",
                     {b0, g0, r0}, fs0, eof0, e0.d, e0.sof, e0.eof);
          end
        end
      end
      if (dv1) begin
        if (chk_runs && run1 == 0) begin
          n_vec++;
          if (q1.size() < 20) begin
            n_fail++;
            $display("FAIL run_start: %0d pixels buffered at burst start, required >= 20", q1.size());
          end
        end
        run1++;
        vcnt1++;
        if (fs1) fscnt1++;
        if (eof1) eofcnt1++;
        n_vec++;
        if (q1.size() == 0) begin
          n_fail++;
          $display("FAIL sb1_unexpected: got data=%h sof=%b eof=%b, required no output", {b1, g1, r1}, fs1, eof1);
        end else begin
          e1 = q1.pop_front();
          if ({b1, g1, r1, fs1, eof1} !== {e1.d, e1.sof, e1.eof}) begin
            n_fail++;
            $display("FAIL sb1_pixel: got data=%h sof=%b eof=%b, required data=%h sof=%b eof=%b",
                     {b1, g1, r1}, fs1, eof1, e1.d, e1.sof, e1.eof);
          end
        end
      end else if (run1 > 0) begin
        if (chk_runs) begin
          runs_seen++;
          n_vec++;
          if (run1 != 20) begin
            n_fail++;
            $display("FAIL run_length: got %0d contiguous pixels, required 20", run1);
          end
        end
        run1 = 0;
      end
    end
  end

  task automatic set_in(input int sel, input bit v, input logic [23:0] d,
                        input logic [1:0] u, input bit l);
    if (sel == 0) begin
      tvalid0 = v; tdata0 = d; tuser0 = u; tlast0 = l;
    end else begin
      tvalid1 = v; tdata1 = d; tuser1 = u; tlast1 = l;
    end
  endtask

  // Drive frames of pixels base+p; queue expectations for accepted beats
  task automatic stream(input int sel, input int hres, input int vres, input int nframes,
                        input int gap_every, input int gap_len, input bit toggle,
                        input bit eof_tag, input bit sof_en, input bit expect_out,
                        input logic [23:0] base, input int max_beats, input bit hold);
    int total, p, acc, gap_rem, guard;
    bit tog, v, rdy, last_px;
    logic [1:0] u;
    exp_t e;
    total = hres * vres;
    if (sel == 0) begin hres0 = hres[15:0]; vres0 = vres[15:0]; end
    else          begin hres1 = hres[15:0]; vres1 = vres[15:0]; end
    acc = 0; gap_rem = 0; guard = 0; tog = 1'b1;
    for (int f = 0; f < nframes; f++) begin
      p = 0;
      while (p < total && acc < max_beats) begin
        @(negedge clk);
        guard++;
        if (guard > 4 * total * nframes + 200) begin
          n_vec++;
          n_fail++;
          $display("FAIL stream_timeout: %0d beats accepted, required %0d", acc, total * nframes);
          set_in(sel, 1'b0, '0, '0, 1'b0);
          return;
        end
        v = 1'b1;
        if (toggle) begin v = tog; tog = ~tog; end
        if (gap_rem > 0) begin v = 1'b0; gap_rem--; end
        last_px = (p == total - 1);
        u = {eof_tag & last_px, sof_en & (p == 0)};
        set_in(sel, v, base + 24'(p), u, ((p % hres) == hres - 1));
        rdy = (sel == 0) ? tready0 : tready1;
        if (v && !rdy && stall_at < 0) begin
          stall_at = acc;
          stall_vcnt = (sel == 0) ? vcnt0 : vcnt1;
        end
        if (v && rdy) begin
          if (expect_out) begin
            e.d = base + 24'(p); e.sof = u[0]; e.eof = last_px;
            if (sel == 0) q0.push_back(e); else q1.push_back(e);
          end
          p++;
          acc++;
          if (gap_every > 0 && (acc % gap_every) == 0) gap_rem = gap_len;
        end
      end
    end
    if (!hold) begin
      @(negedge clk);
      set_in(sel, 1'b0, '0, '0, 1'b0);
    end
  endtask

  task automatic wait_drain(input int sel);
    int guard;
    guard = 0;
    while (((sel == 0) ? q0.size() : q1.size()) != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    n_vec++;
    if (guard >= 200) begin
      n_fail++;
      $display("FAIL drain%0d: %0d pixels outstanding, required 0", sel,
               (sel == 0) ? q0.size() : q1.size());
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic clear_counts;
    vcnt0 = 0; fscnt0 = 0; eofcnt0 = 0;
    vcnt1 = 0; fscnt1 = 0; eofcnt1 = 0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_in(0, 1'b0, '0, '0, 1'b0);
    set_in(1, 1'b0, '0, '0, 1'b0);
    hres0 = 16'd1; vres0 = 16'd1; hres1 = 16'd1; vres1 = 16'd1;
    repeat (5) @(negedge clk);
    n_vec++;
    if ({tready0, dv0, r0, g0, b0, fs0, eof0} !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_outputs0: got %h, required 0", {tready0, dv0, r0, g0, b0, fs0, eof0});
    end
    n_vec++;
    if ({tready1, dv1, r1, g1, b1, fs1, eof1} !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_outputs1: got %h, required 0", {tready1, dv1, r1, g1, b1, fs1, eof1});
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({tready0, tready1} !== 2'b11) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b, required 11", {tready0, tready1});
    end
  endtask

  task automatic test_frame;
    clear_counts();
    stream(0, 100, 100, 1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h0, BIG, 1'b0);
    wait_drain(0);
    n_vec++;
    if (vcnt0 != 10000 || fscnt0 != 1 || eofcnt0 != 1) begin
      n_fail++;
      $display("FAIL frame_counts: got valid=%0d sof=%0d eof=%0d, required 10000 1 1", vcnt0, fscnt0, eofcnt0);
    end
  endtask

  task automatic test_gaps;
    clear_counts();
    stream(0, 100, 100, 2, 30, 4, 1'b0, 1'b1, 1'b1, 1'b1, 24'h0, BIG, 1'b0);
    wait_drain(0);
    n_vec++;
    if (vcnt0 != 20000 || fscnt0 != 2 || eofcnt0 != 2) begin
      n_fail++;
      $display("FAIL gap_counts: got valid=%0d sof=%0d eof=%0d, required 20000 2 2", vcnt0, fscnt0, eofcnt0);
    end
  endtask

  task automatic test_debubble;
    clear_counts();
    run1 = 0; runs_seen = 0; chk_runs = 1'b1;
    stream(1, 20, 3, 1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 24'h100000, BIG, 1'b0);
    wait_drain(1);
    chk_runs = 1'b0;
    n_vec++;
    if (runs_seen != 3 || vcnt1 != 60 || fscnt1 != 1 || eofcnt1 != 1) begin
      n_fail++;
      $display("FAIL debubble_counts: got runs=%0d valid=%0d sof=%0d eof=%0d, required 3 60 1 1",
               runs_seen, vcnt1, fscnt1, eofcnt1);
    end
  endtask

  task automatic test_stall;
    clear_counts();
    stall_at = -1; stall_vcnt = -1; run1 = 0;
    stream(1, 64, 1, 1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h200000, BIG, 1'b0);
    wait_drain(1);
    n_vec++;
    if (stall_at != 32 || stall_vcnt != 0) begin
      n_fail++;
      $display("FAIL stall_point: ready fell after %0d beats with %0d outputs, required 32 and 0",
               stall_at, stall_vcnt);
    end
    n_vec++;
    if (vcnt1 != 64 || fscnt1 != 1 || eofcnt1 != 1) begin
      n_fail++;
      $display("FAIL stall_counts: got valid=%0d sof=%0d eof=%0d, required 64 1 1", vcnt1, fscnt1, eofcnt1);
    end
  endtask

  task automatic test_reset_midline;
    stream(0, 100, 100, 1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h300000, 50, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({tready0, dv0, r0, g0, b0, fs0, eof0} !== 29'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %h, required 0", {tready0, dv0, r0, g0, b0, fs0, eof0});
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if (tready0 !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_in_reset: got %b with tvalid high, required 0", tready0);
    end
    q0.delete();
    q1.delete();
    set_in(0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    clear_counts();
    stream(0, 10, 10, 1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h400000, BIG, 1'b0);
    wait_drain(0);
    n_vec++;
    if (vcnt0 != 100 || fscnt0 != 1 || eofcnt0 != 1) begin
      n_fail++;
      $display("FAIL post_reset_counts: got valid=%0d sof=%0d eof=%0d, required 100 1 1", vcnt0, fscnt0, eofcnt0);
    end
  endtask

`ifdef AXIS_VIDEO_SOF_RESYNC_EN
  task automatic test_resync;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_counts();
    stream(0, 37, 1, 1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 24'hABC000, BIG, 1'b0);
    stream(0, 4, 4, 1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h500000, BIG, 1'b0);
    wait_drain(0);
    n_vec++;
    if (vcnt0 != 16 || fscnt0 != 1 || eofcnt0 != 1) begin
      n_fail++;
      $display("FAIL resync_counts: got valid=%0d sof=%0d eof=%0d, required 16 1 1", vcnt0, fscnt0, eofcnt0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_gaps();
    test_debubble();
    test_stall();
    test_reset_midline();
`ifdef AXIS_VIDEO_SOF_RESYNC_EN
    test_resync();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
